// File: rtl/obi_bram_ctrl.sv
// OBI subordinate front-end for one port of a dual-port block RAM.
// Converts OBI req/gnt/rvalid into BRAM en/we/regce strobes, covers a 1- or
// 2-cycle read latency and performs byte-masked writes as read-modify-write.
// Optional macro OBI_BRAM_RANGE_CHECK_EN: out-of-range or misaligned requests
// are answered with err_o and never touch the RAM.
module obi_bram_ctrl #(
  parameter int RAM_WIDTH    = 32,
  parameter int RAM_DEPTH    = 1024,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_i,
  output logic                         gnt_o,
  input  logic [ADDR_WIDTH-1:0]        addr_i,
  input  logic                         we_i,
  input  logic [RAM_WIDTH/8-1:0]       be_i,
  input  logic [RAM_WIDTH-1:0]         wdata_i,
  output logic                         rvalid_o,
  output logic [RAM_WIDTH-1:0]         rdata_o,
  output logic                         err_o,
  output logic                         ram_en_o,
  output logic                         ram_we_o,
  output logic                         ram_regce_o,
  output logic [$clog2(RAM_DEPTH)-1:0] ram_addr_o,
  output logic [RAM_WIDTH-1:0]         ram_din_o,
  input  logic [RAM_WIDTH-1:0]         ram_dout_i
);

  localparam int NB = RAM_WIDTH / 8;
  localparam int AW = $clog2(RAM_DEPTH);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RMW_RD, RMW_WR, RESP} state_e;

  state_e                 state_q;
  logic [AW-1:0]          addr_q;
  logic [NB-1:0]          be_q;
  logic [RAM_WIDTH-1:0]   wdata_q;
  logic                   wait_q;   // second read cycle reached (latency 2)

  logic                   be_full, be_none, addr_bad, acc, rd_done;
  logic [AW-1:0]          addr_idx;
  logic [RAM_WIDTH-1:0]   merged;
  logic                   unused_addr;

  assign be_full  = &be_i;
  assign be_none  = ~|be_i;
  assign addr_idx = addr_i[AW+1:2];
  // Upper address bits only matter for the range check; the word index wraps.
  assign unused_addr = ^{addr_i[ADDR_WIDTH-1:AW+2], addr_i[1:0]};

`ifdef OBI_BRAM_RANGE_CHECK_EN
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(RAM_DEPTH * 4);
  logic err_q;
  assign addr_bad = ({1'b0, addr_i} >= LIMIT) || (addr_i[1:0] != 2'b00);
  assign err_o    = (state_q == RESP) && err_q;
`else
  assign addr_bad = 1'b0;
  assign err_o    = 1'b0;
`endif

  // Grant only when idle; held low while reset is asserted.
  assign gnt_o   = req_i && rst_ni && (state_q == IDLE);
  // RAM is touched at the grant cycle unless the request is rejected or empty.
  assign acc     = gnt_o && !addr_bad && !(we_i && be_none);
  assign rd_done = (state_q == RD_WAIT) && ((READ_LATENCY == 1) || wait_q);

  // Byte merge for the write half of a read-modify-write.
  always_comb begin
    merged = '0;
    for (int k = 0; k < NB; k++)
      merged[8*k +: 8] = be_q[k] ? wdata_q[8*k +: 8] : ram_dout_i[8*k +: 8];
  end

  assign ram_en_o    = acc || (state_q == RMW_WR);
  assign ram_we_o    = (acc && we_i && be_full) || (state_q == RMW_WR);
  assign ram_regce_o = (READ_LATENCY == 2) &&
                       (((state_q == RD_WAIT) && !wait_q) || (state_q == RMW_RD));
  assign ram_addr_o  = (state_q == IDLE) ? (gnt_o ? addr_idx : '0) : addr_q;
  assign ram_din_o   = (state_q == RMW_WR)          ? merged  :
                       (acc && we_i && be_full)     ? wdata_i : '0;
  assign rvalid_o    = rd_done || (state_q == RESP);
  assign rdata_o     = rd_done ? ram_dout_i : '0;

  // Transaction FSM: latch the request at grant, then sequence read/RMW/response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      wait_q  <= 1'b0;
`ifdef OBI_BRAM_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (gnt_o) begin
          addr_q  <= addr_idx;
          be_q    <= be_i;
          wdata_q <= wdata_i;
          wait_q  <= 1'b0;
`ifdef OBI_BRAM_RANGE_CHECK_EN
          err_q   <= addr_bad;
`endif
          if (addr_bad)                state_q <= RESP;
          else if (!we_i)              state_q <= RD_WAIT;
          else if (be_full || be_none) state_q <= RESP;
          else                         state_q <= (READ_LATENCY == 1) ? RMW_WR : RMW_RD;
        end
        RD_WAIT: begin
          if (rd_done) state_q <= IDLE;
          else         wait_q  <= 1'b1;
        end
        RMW_RD:  state_q <= RMW_WR;
        RMW_WR:  state_q <= RESP;
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_bram_ctrl.sv
// Directed bench for obi_bram_ctrl: DUT 0 uses READ_LATENCY=1, DUT 1 uses
// READ_LATENCY=2, each with its own behavioural BRAM port model.
module tb_obi_bram_ctrl;

  logic        gclk = 1'b0;
  logic        grst_n = 1'b0;
  always #5 gclk = ~gclk;

  logic        req [2], we [2], gnt [2], rvalid [2], err [2], en [2], rwe [2], regce [2];
  logic [3:0]  be [2];
  logic [31:0] addr [2], wdata [2], rdata [2], din [2];
  logic [9:0]  raddr [2];
  logic [31:0] dout0, dout1, lat1;
  logic [31:0] mem0 [0:1023] = '{default: '0};
  logic [31:0] mem1 [0:1023] = '{default: '0};

  int ncmp = 0;
  int nerr = 0;

  obi_bram_ctrl #(.READ_LATENCY(1)) u_dut0 (
    .clk_i(gclk), .rst_ni(grst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
    .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
    .err_o(err[0]), .ram_en_o(en[0]), .ram_we_o(rwe[0]), .ram_regce_o(regce[0]),
    .ram_addr_o(raddr[0]), .ram_din_o(din[0]), .ram_dout_i(dout0));

  obi_bram_ctrl #(.READ_LATENCY(2)) u_dut1 (
    .clk_i(gclk), .rst_ni(grst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
    .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
    .err_o(err[1]), .ram_en_o(en[1]), .ram_we_o(rwe[1]), .ram_regce_o(regce[1]),
    .ram_addr_o(raddr[1]), .ram_din_o(din[1]), .ram_dout_i(dout1));

  // BRAM port without output register
  always @(posedge gclk)
    if (en[0]) begin
      if (rwe[0]) mem0[raddr[0]] <= din[0];
      else        dout0 <= mem0[raddr[0]];
    end

  // BRAM port with output register
  always @(posedge gclk) begin
    if (en[1]) begin
      if (rwe[1]) mem1[raddr[1]] <= din[1];
      else        lat1 <= mem1[raddr[1]];
    end
    if (regce[1]) dout1 <= lat1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One OBI transaction; req stays high until the response to prove no early grant.
  task automatic xact(input int d, input bit w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] er, input logic [31:0] edin,
                      input int elat, input int ewe, input int een, input int erce,
                      input bit eerr, input string tag);
    int n, lat, nwe, nen, nrce, xg;
    logic [31:0] wdin, rd;
    logic        e;
    @(posedge gclk); #1;
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
    @(negedge gclk);
    n = 0;
    while (!gnt[d] && n < 4) begin @(negedge gclk); n++; end
    chk({tag, " gnt"}, 32'(gnt[d]), 1);
    chk({tag, " gnt_wait"}, 32'(n), 0);
    chk({tag, " regce@T"}, 32'(regce[d]), 0);
    if (een > 0) chk({tag, " addr@T"}, 32'(raddr[d]), 32'(a[11:2]));
    nwe = 32'(rwe[d]); nen = 32'(en[d]); nrce = 0; xg = 0;
    wdin = rwe[d] ? din[d] : 32'h0;
    lat = 0; rd = '0; e = 1'b0;
    do begin
      @(negedge gclk);
      lat++;
      nwe += 32'(rwe[d]); nen += 32'(en[d]); nrce += 32'(regce[d]); xg += 32'(gnt[d]);
      if (rwe[d]) wdin = din[d];
      rd = rdata[d]; e = err[d];
    end while (!rvalid[d] && lat < 8);
    @(posedge gclk); #1;
    req[d] = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " rdata"}, rd, er);
    chk({tag, " err"}, 32'(e), 32'(eerr));
    chk({tag, " we_pulses"}, 32'(nwe), 32'(ewe));
    chk({tag, " en_cycles"}, 32'(nen), 32'(een));
    chk({tag, " regce_cycles"}, 32'(nrce), 32'(erce));
    chk({tag, " busy_gnt"}, 32'(xg), 0);
    if (ewe > 0) chk({tag, " din"}, wdin, edin);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b1; we[d] = 1'b1; be[d] = 4'hF; addr[d] = 32'h10; wdata[d] = 32'hDEADBEEF;
    end
    // Reset held with requests pending
    repeat (2) @(negedge gclk);
    chk("rst gnt0", 32'(gnt[0]), 0);
    chk("rst rvalid0", 32'(rvalid[0]), 0);
    chk("rst en0", 32'(en[0]), 0);
    chk("rst we0", 32'(rwe[0]), 0);
    chk("rst rdata0", rdata[0], 0);
    chk("rst raddr0", 32'(raddr[0]), 0);
    chk("rst din0", din[0], 0);
    chk("rst err0", 32'(err[0]), 0);
    chk("rst gnt1", 32'(gnt[1]), 0);
    chk("rst en1", 32'(en[1]), 0);
    chk("rst regce1", 32'(regce[1]), 0);
    @(posedge gclk); #1;
    req[0] = 1'b0; req[1] = 1'b0; grst_n = 1'b1;

    // READ_LATENCY = 1
    xact(0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1, 1, 1, 0, 0, "wr10");
    xact(0, 0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0, 1, 0, 1, 0, 0, "rd10");
    xact(0, 1, 4'hF, 32'h20, 32'h11223344, 32'h0, 32'h11223344, 1, 1, 1, 0, 0, "wr20");
    xact(0, 1, 4'b0101, 32'h20, 32'hAABBCCDD, 32'h0, 32'h11BB33DD, 2, 1, 2, 0, 0, "rmw20");
    xact(0, 0, 4'hF, 32'h20, 32'h0, 32'h11BB33DD, 32'h0, 1, 0, 1, 0, 0, "rd20");
    xact(0, 1, 4'h0, 32'h20, 32'hFFFFFFFF, 32'h0, 32'h0, 1, 0, 0, 0, 0, "be0");
    xact(0, 0, 4'hF, 32'h20, 32'h0, 32'h11BB33DD, 32'h0, 1, 0, 1, 0, 0, "rd20b");
    xact(0, 1, 4'hF, 32'hFFC, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 1, 1, 1, 0, 0, "wrFFC");
    xact(0, 0, 4'hF, 32'hFFC, 32'h0, 32'hCAFEF00D, 32'h0, 1, 0, 1, 0, 0, "rdFFC");
`ifdef OBI_BRAM_RANGE_CHECK_EN
    xact(0, 0, 4'hF, 32'h1000, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0, 1, "oob1000");
    xact(0, 1, 4'hF, 32'h1010, 32'h12345678, 32'h0, 32'h0, 1, 0, 0, 0, 1, "oobwr");
    xact(0, 0, 4'hF, 32'h12, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0, 1, "misalign");
    xact(0, 0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0, 1, 0, 1, 0, 0, "rd10c");
`else
    xact(0, 0, 4'hF, 32'h1010, 32'h0, 32'hDEADBEEF, 32'h0, 1, 0, 1, 0, 0, "wrap1010");
    xact(0, 0, 4'hF, 32'h1000, 32'h0, 32'h0, 32'h0, 1, 0, 1, 0, 0, "wrap1000");
    xact(0, 0, 4'hF, 32'h12, 32'h0, 32'hDEADBEEF, 32'h0, 1, 0, 1, 0, 0, "lowbits");
`endif

    // Reset in the middle of a read-modify-write aborts it
    @(posedge gclk); #1;
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'b0001; addr[0] = 32'h30; wdata[0] = 32'hFF;
    @(negedge gclk);
    chk("abort gnt", 32'(gnt[0]), 1);
    @(posedge gclk); #1;
    req[0] = 1'b0; grst_n = 1'b0;
    @(negedge gclk);
    chk("abort we", 32'(rwe[0]), 0);
    chk("abort en", 32'(en[0]), 0);
    chk("abort rvalid", 32'(rvalid[0]), 0);
    #1 grst_n = 1'b1;
    xact(0, 0, 4'hF, 32'h30, 32'h0, 32'h0, 32'h0, 1, 0, 1, 0, 0, "rd30");

    // READ_LATENCY = 2
    xact(1, 1, 4'hF, 32'h10, 32'h12345678, 32'h0, 32'h12345678, 1, 1, 1, 0, 0, "L2wr");
    xact(1, 0, 4'hF, 32'h10, 32'h0, 32'h12345678, 32'h0, 2, 0, 1, 1, 0, "L2rd");
    xact(1, 1, 4'b1000, 32'h10, 32'hAA000000, 32'h0, 32'hAA345678, 3, 1, 2, 1, 0, "L2rmw");
    xact(1, 0, 4'hF, 32'h10, 32'h0, 32'hAA345678, 32'h0, 2, 0, 1, 1, 0, "L2rd2");
    xact(1, 1, 4'h0, 32'h10, 32'hFFFFFFFF, 32'h0, 32'h0, 1, 0, 0, 0, 0, "L2be0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/obi_bram_ctrl.md
Name: obi_bram_ctrl

Overview:
- OBI subordinate front-end driving one port of the FPGA dual-port block RAM.
- Converts OBI req/gnt/rvalid transactions into BRAM en/we/regce strobes and handles read latency (1 or 2 cycles).
- The RAM has a single whole-word write enable, so byte-masked writes are done as read-modify-write.
- Sits between the interconnect and the RAM; one instance per RAM port.

Parameters:
- RAM_WIDTH, 32, data width in bits; must be a multiple of 8.
- RAM_DEPTH, 1024, number of words.
- READ_LATENCY, 1, BRAM read latency: 1 = no output register, 2 = output register used (regce driven).
- ADDR_WIDTH, 32, OBI byte-address width.

Ports:
- clk_i  in  1  clock; also clocks the RAM port.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  OBI request.
- gnt_o  out  1  OBI grant.
- addr_i  in  ADDR_WIDTH  OBI byte address.
- we_i  in  1  OBI write enable.
- be_i  in  RAM_WIDTH/8  OBI byte enables.
- wdata_i  in  RAM_WIDTH  OBI write data.
- rvalid_o  out  1  OBI response valid.
- rdata_o  out  RAM_WIDTH  OBI read data.
- err_o  out  1  OBI error response.
- ram_en_o  out  1  RAM port enable.
- ram_we_o  out  1  RAM port write enable.
- ram_regce_o  out  1  RAM output register enable (tied 0 when READ_LATENCY=1).
- ram_addr_o  out  clog2(RAM_DEPTH)  RAM word address = addr_i[clog2(RAM_DEPTH)+1:2].
- ram_din_o  out  RAM_WIDTH  RAM write data.
- ram_dout_i  in  RAM_WIDTH  RAM read data.

Behaviour:
- Reset: state IDLE; gnt_o, rvalid_o, err_o, ram_en_o, ram_we_o and ram_regce_o are 0; rdata_o, ram_addr_o and ram_din_o are 0.
- Reset asserted mid-transaction aborts the transaction; no response is issued and no RAM write occurs after reset is asserted.
- At most one transaction is outstanding at a time.
- gnt_o = req_i && state==IDLE (combinational). A granted cycle is called T.
- States:
  - IDLE
  - RD_WAIT
  - RMW_RD
  - RMW_WR
  - RESP
- Read (we_i=0), granted at T:
  - ram_en_o=1, ram_we_o=0 at T; transition to RD_WAIT.
  - READ_LATENCY=2: ram_regce_o=1 at T+1.
  - At T+READ_LATENCY: rvalid_o=1 and rdata_o=ram_dout_i; return to IDLE.
  - Next grant possible at T+READ_LATENCY+1.
- Full write (we_i=1, be_i all ones), granted at T:
  - ram_en_o=1, ram_we_o=1, ram_din_o=wdata_i at T; transition to RESP.
  - rvalid_o=1 at T+1, rdata_o=0; return to IDLE.
- Partial write (be_i neither all ones nor 0), granted at T:
  - Latch addr, be and wdata; read issued at T (RMW_RD).
  - At T+READ_LATENCY, state RMW_WR: ram_en_o=1, ram_we_o=1, same address.
  - Byte k of ram_din_o = be[k] ? wdata byte k : ram_dout_i byte k.
  - rvalid_o=1 at T+READ_LATENCY+1.
- Write with be_i==0: no RAM access; rvalid_o at T+1.
- rvalid_o is a single-cycle pulse per granted request; there is no back-pressure on the response.
- ram_en_o is 0 in every cycle without an access. Address bits above the word index are ignored (wrap modulo RAM_DEPTH).
- Without the optional feature, err_o is constantly 0.

Optional Feature:
- Macro: OBI_BRAM_RANGE_CHECK_EN.
- Defined: a request with addr_i >= RAM_DEPTH*4, or addr_i[1:0] != 0, is granted but performs no RAM access (ram_en_o stays 0). It receives rvalid_o=1 and err_o=1 at T+1, with rdata_o=0.
- Undefined: no checking, err_o tied 0, and addresses wrap as above.

Test Plan:
- Reset: hold rst_ni=0 with req_i=1 -> gnt_o=0, rvalid_o=0, ram_en_o=0; after release, first grant in the next cycle with req_i=1.
- Full write 0xDEADBEEF to 0x10, then read 0x10, READ_LATENCY=1 -> write: ram_we_o at T, rvalid at T+1. Read: rvalid at T+1 with rdata_o=0xDEADBEEF.
- Partial write: word 0x11223344 at 0x20, then write be=4'b0101 with wdata 0xAABBCCDD -> read returns 0x11BB33DD; RMW write cycle at T+READ_LATENCY.
- READ_LATENCY=2 read -> ram_regce_o=1 at T+1 only, rvalid_o at T+2; gnt_o stays 0 at T+1 and T+2 despite req_i held at 1.
- be_i=0 write to an initialised word -> no ram_we_o pulse, rvalid_o at T+1, and a subsequent read shows the word unchanged.
- With OBI_BRAM_RANGE_CHECK_EN, RAM_DEPTH=1024, read 0x1000 -> err_o=1 and rvalid_o=1 at T+1, ram_en_o never asserted. Read 0x0FFC -> normal response with err_o=0.
